// File: rtl/core_mem_arbiter.sv
// Shares one memory port between fetch (read-only) and load/store; one transaction in flight, grant is combinational in IDLE.
// Request is held in REQ until i_mem_ready; responses return one cycle after i_mem_rvalid; gnt is withheld while busy.
module core_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LS_STREAK_MAX  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [DATA_W/8-1:0] i_ls_be,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy,
  output logic                o_bus_err
);
  localparam int BE_W  = DATA_W / 8;
  localparam int STK_W = (LS_STREAK_MAX > 0) ? $clog2(LS_STREAK_MAX + 1) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  state_e            state_q, state_d;
  mem_cmd_t          cmd_q, cmd_d;
  logic              owner_ls_q, owner_ls_d;
  logic              discard_q, discard_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [STK_W-1:0]  streak_q, streak_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              bus_err_q, bus_err_d;

  logic              if_win, ls_win;
  logic              streak_sat, streak_full;
  logic              rsp_done, tmo_hit, flush_hit, discard_now;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_req;

  assign streak_sat  = (streak_q == STK_W'(LS_STREAK_MAX));
  assign streak_full = (LS_STREAK_MAX != 0) && streak_sat;
  assign cnt_inc     = cnt_q + 1'b1;

  // Fetch only jumps ahead of a contending load/store once the streak is full.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (rstn && (state_q == IDLE)) begin
      if (i_ls_req && !(i_if_req && streak_full)) begin
        ls_win = 1'b1;
      end else if (i_if_req) begin
        if_win = 1'b1;
      end
    end
  end

  assign rsp_done    = (state_q == RESP) && i_mem_rvalid;
  assign tmo_hit     = (TIMEOUT_CYCLES != 0) && (state_q == RESP) && !i_mem_rvalid &&
                       (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
  assign flush_hit   = i_if_flush && !owner_ls_q && ((state_q == REQ) || (state_q == RESP));
  assign discard_now = discard_q || flush_hit;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      owner_ls_q  <= 1'b0;
      discard_q   <= 1'b0;
      cnt_q       <= '0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      owner_ls_q  <= owner_ls_d;
      discard_q   <= discard_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_win || ls_win) state_d = REQ;
      REQ:     if (i_mem_ready) state_d = RESP;
      RESP:    if (rsp_done || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d      = cmd_q;
    owner_ls_d = owner_ls_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    if (ls_win) begin
      cmd_d.we    = i_ls_we;
      cmd_d.be    = i_ls_be;
      cmd_d.addr  = i_ls_addr;
      cmd_d.wdata = i_ls_wdata;
      owner_ls_d  = 1'b1;
      if (i_if_req && !streak_sat) streak_d = streak_q + 1'b1;
    end else if (if_win) begin
      cmd_d.we    = 1'b0;
      cmd_d.be    = {BE_W{1'b1}};
      cmd_d.addr  = i_if_addr;
      cmd_d.wdata = '0;
      owner_ls_d  = 1'b0;
      streak_d    = '0;
    end
    if (if_win || ls_win) begin
      discard_d = 1'b0;
      cnt_d     = '0;
    end
    if (flush_hit) discard_d = 1'b1;
    if ((state_q == RESP) && !i_mem_rvalid) cnt_d = cnt_inc;
  end

  // Store acks pulse rvalid but carry no data, so o_ls_rdata keeps the last load value.
  always_comb begin
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    bus_err_d   = tmo_hit;
    rsp_data    = tmo_hit ? '0 : i_mem_rdata;
    if (rsp_done || tmo_hit) begin
      if (owner_ls_q) begin
        ls_rvalid_d = 1'b1;
        if (!cmd_q.we) ls_rdata_d = rsp_data;
      end else if (!discard_now) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = rsp_data;
      end
    end
  end

  assign mem_req     = rstn && (state_q == REQ);
  assign o_mem_req   = mem_req;
  assign o_mem_we    = mem_req ? cmd_q.we    : 1'b0;
  assign o_mem_be    = mem_req ? cmd_q.be    : '0;
  assign o_mem_addr  = mem_req ? cmd_q.addr  : '0;
  assign o_mem_wdata = mem_req ? cmd_q.wdata : '0;

  assign o_if_gnt    = if_win;
  assign o_ls_gnt    = ls_win;
  assign o_if_rvalid = if_rvalid_q;
  assign o_ls_rvalid = ls_rvalid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_bus_err   = bus_err_q;
  assign o_busy      = rstn && (state_q != IDLE);

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch stage (read-only) and the load/store stage (read/write).
- Sits between the core datapath and the memory/bus interface.
- Accepts one request at a time and holds it until the memory port accepts it.
- Routes the response back to the owning requester.
- Supports discarding in-flight fetch responses on a pipeline flush, with a bounded response timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- LS_STREAK_MAX, 4, number of consecutive LS grants won while IF was also requesting before IF is forced ahead once; 0 = strict LS priority.
- TIMEOUT_CYCLES, 255, maximum cycles in RESP before an error is forced; 0 = timeout disabled.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- i_if_req  in  1  fetch request; held until o_if_gnt
- i_if_addr  in  ADDR_W  fetch address
- i_if_flush  in  1  discard any outstanding fetch response
- o_if_gnt  out  1  fetch request accepted (1-cycle pulse)
- o_if_rvalid  out  1  fetch data valid (1-cycle pulse)
- o_if_rdata  out  DATA_W  fetch data
- i_ls_req  in  1  load/store request; held until o_ls_gnt
- i_ls_we  in  1  1 = store
- i_ls_be  in  DATA_W/8  byte enables
- i_ls_addr  in  ADDR_W  load/store address
- i_ls_wdata  in  DATA_W  store data
- o_ls_gnt  out  1  load/store request accepted (pulse)
- o_ls_rvalid  out  1  load data / store ack (pulse)
- o_ls_rdata  out  DATA_W  load data
- o_mem_req  out  1  memory request valid
- o_mem_we  out  1  memory write
- o_mem_be  out  DATA_W/8  memory byte enables
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- i_mem_ready  in  1  memory accepts the request this cycle
- i_mem_rvalid  in  1  response valid (reads and writes)
- i_mem_rdata  in  DATA_W  response data
- o_busy  out  1  transaction in flight (state != IDLE)
- o_bus_err  out  1  1-cycle pulse on timeout

Behaviour:
- FSM has three states: IDLE, REQ, RESP.
- IDLE, no request: stay.
- IDLE, any request: arbitrate combinationally; pulse the winner's gnt in the same cycle.
  - Latch owner, we, be, addr, wdata. IF requests latch we=0 and be=all ones.
  - Clear the discard flag and the timeout counter; go to REQ.
- Arbitration:
  - LS wins by default.
  - IF wins only if IF alone requests, or both request and streak == LS_STREAK_MAX (with LS_STREAK_MAX != 0).
  - streak increments on an LS grant while i_if_req=1, saturating at LS_STREAK_MAX.
  - streak clears on any IF grant.
- REQ:
  - o_mem_req=1 with the latched fields, held stable until i_mem_ready=1, then go to RESP.
  - Memory fields are 0 whenever o_mem_req=0.
- RESP, on i_mem_rvalid:
  - Pulse the owner's rvalid with rdata=i_mem_rdata. Store acks also pulse o_ls_rvalid.
  - Go to IDLE.
- i_mem_rvalid in IDLE or REQ is ignored.
- rdata outputs are registered, update only on an rvalid pulse, and hold otherwise.
- Latency:
  - Grant in cycle 0, o_mem_req from cycle 1.
  - Earliest rvalid is the cycle after i_mem_rvalid.
  - Peak throughput is one transaction per 3 cycles, assuming zero-wait memory with rvalid the cycle after ready.
- Flush:
  - i_if_flush=1 in REQ or RESP while owner=IF sets the discard flag.
  - The memory transaction still completes, but o_if_rvalid is suppressed.
  - Flush in the same cycle as the IF response also suppresses it.
  - Flush has no effect on an LS owner.
  - Flush in IDLE is ignored; the requester must drop i_if_req.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter increments each RESP cycle without i_mem_rvalid.
  - On reaching TIMEOUT_CYCLES: pulse o_bus_err, pulse the owner's rvalid with rdata=0 (unless discarded), go to IDLE.
- Simultaneous rvalid and timeout: rvalid wins, no error.
- Reset (synchronous, rstn=0):
  - State IDLE; streak, counter, discard flag and latches cleared.
  - All outputs 0.
  - Reset mid-transaction abandons it; no rvalid is emitted, and a late i_mem_rvalid is ignored.
  - Gnt is suppressed while rstn=0.

Test Plan:
- Single IF read: i_if_req, addr 0x100, ready immediately, rvalid next cycle with data 0xDEADBEEF -> o_if_gnt at cycle 0, o_mem_req at cycle 1 with addr 0x100, we=0, be=0xF; o_if_rvalid at cycle 3 with rdata 0xDEADBEEF.
- Contention, LS_STREAK_MAX=4: both requesting continuously -> grant order LS,LS,LS,LS,IF,LS,...; strict LS order when the parameter is 0.
- Store with wait states: LS we=1, be=0x3, addr 0x2000, wdata 0x1234; i_mem_ready low for 3 cycles -> fields stable for all 4 REQ cycles; o_ls_rvalid on ack; o_ls_rdata unchanged.
- Flush: IF fetch in RESP, i_if_flush pulsed -> memory completes, no o_if_rvalid, o_busy drops; the next LS request is served normally.
- Timeout, TIMEOUT_CYCLES=8: no rvalid -> o_bus_err plus owner rvalid with rdata 0 after 8 RESP cycles; simultaneous rvalid at cycle 8 -> no error.
- Reset in RESP: rstn low 1 cycle, then i_mem_rvalid -> no rvalid out, o_busy=0, all outputs 0.
